// File: rtl/cache_fill_ctrl.sv
// Miss-handling fill controller for the 2-way set-associative data cache.
// Picks a victim way, streams one block from memory into it word by word,
// then rewrites tag/valid/LRU metadata for both ways of the set.
module cache_fill_ctrl #(
  parameter int unsigned WORDS = 8,
  parameter int unsigned TAG_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_detected,
  input  logic [15:0]        miss_address,
  input  logic [TAG_W+1:0]   meta1,
  input  logic [TAG_W+1:0]   meta2,
  input  logic               mem_data_valid,
  input  logic [15:0]        mem_data_in,
  output logic               fsm_busy,
  output logic               mem_read_en,
  output logic [15:0]        mem_addr,
  output logic               data_write1,
  output logic               data_write2,
  output logic [WORDS-1:0]   word_en,
  output logic [15:0]        data_out,
  output logic               meta_write1,
  output logic               meta_write2,
  output logic [TAG_W+1:0]   meta_out1,
  output logic [TAG_W+1:0]   meta_out2,
  output logic               fill_done
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OFF_W  = $clog2(WORDS);
  localparam int unsigned CNT_W  = OFF_W + 1;
  localparam int unsigned META_W = TAG_W + 2;
  localparam int unsigned BLK_W  = ADDR_W - OFF_W - 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [CNT_W-1:0]  issueCnt;
  logic [CNT_W-1:0]  recvCnt;
  logic [BLK_W-1:0]  blkAddr;
  logic [META_W-1:0] meta1Q;
  logic [META_W-1:0] meta2Q;
  logic              victim2;
  logic              victim2New;
  logic              accept;
  logic [META_W-1:0] newMeta;
  logic              unusedAddrBits;

  // Byte/word offset of the missing access does not matter: the whole block is fetched.
  assign unusedAddrBits = ^miss_address[OFF_W:0];

  assign accept  = (state == IDLE) && miss_detected;
  assign newMeta = {2'b10, blkAddr[BLK_W-1 -: TAG_W]};

  // Victim choice: fill an invalid way first; with both valid, evict way 2 only if it alone is LRU.
  always_comb begin
    victim2New = 1'b0;
    if (!meta1[META_W-1]) begin
      victim2New = 1'b0;
    end else if (!meta2[META_W-1]) begin
      victim2New = 1'b1;
    end else if (meta2[META_W-2] && !meta1[META_W-2]) begin
      victim2New = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and output decode; strobes are suppressed while reset is held.
  always_comb begin
    stateNext   = state;
    fsm_busy    = (state != IDLE);
    mem_read_en = 1'b0;
    mem_addr    = '0;
    data_write1 = 1'b0;
    data_write2 = 1'b0;
    word_en     = '0;
    data_out    = '0;
    meta_write1 = 1'b0;
    meta_write2 = 1'b0;
    meta_out1   = '0;
    meta_out2   = '0;
    fill_done   = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          stateNext = FILL;
        end
      end
      FILL: begin
        if (issueCnt < CNT_W'(WORDS)) begin
          mem_read_en = 1'b1;
          mem_addr    = {blkAddr, issueCnt[OFF_W-1:0], 1'b0};
        end
        if (mem_data_valid && (recvCnt < CNT_W'(WORDS))) begin
          data_write1 = !victim2;
          data_write2 = victim2;
          word_en     = WORDS'(1) << recvCnt[OFF_W-1:0];
          data_out    = mem_data_in;
          if (recvCnt == CNT_W'(WORDS - 1)) begin
            stateNext = UPDATE;
          end
        end
      end
      UPDATE: begin
        meta_write1 = 1'b1;
        meta_write2 = 1'b1;
        fill_done   = 1'b1;
        if (victim2) begin
          meta_out1 = {meta1Q[META_W-1], 1'b1, meta1Q[TAG_W-1:0]};
          meta_out2 = newMeta;
        end else begin
          meta_out1 = newMeta;
          meta_out2 = {meta2Q[META_W-1], 1'b1, meta2Q[TAG_W-1:0]};
        end
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (rst) begin
      mem_read_en = 1'b0;
      data_write1 = 1'b0;
      data_write2 = 1'b0;
      meta_write1 = 1'b0;
      meta_write2 = 1'b0;
      fill_done   = 1'b0;
    end
  end

  // Miss latches and issue/receive counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      issueCnt <= '0;
      recvCnt  <= '0;
      blkAddr  <= '0;
      meta1Q   <= '0;
      meta2Q   <= '0;
      victim2  <= 1'b0;
    end else if (accept) begin
      issueCnt <= '0;
      recvCnt  <= '0;
      blkAddr  <= miss_address[ADDR_W-1:OFF_W+1];
      meta1Q   <= meta1;
      meta2Q   <= meta2;
      victim2  <= victim2New;
    end else begin
      if (mem_read_en) begin
        issueCnt <= issueCnt + CNT_W'(1);
      end
      if (data_write1 || data_write2) begin
        recvCnt <= recvCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: a reference model queues the expected
// requests, data writes and metadata update per miss; a monitor pops and
// compares whenever the DUT strobes; a memory responder returns words.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [7:0]  meta1;
  logic [7:0]  meta2;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] mem_addr;
  logic        data_write1;
  logic        data_write2;
  logic [7:0]  word_en;
  logic [15:0] data_out;
  logic        meta_write1;
  logic        meta_write2;
  logic [7:0]  meta_out1;
  logic [7:0]  meta_out2;
  logic        fill_done;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.WORDS(8), .TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .meta1(meta1), .meta2(meta2),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .fsm_busy(fsm_busy), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .data_write1(data_write1), .data_write2(data_write2),
    .word_en(word_en), .data_out(data_out),
    .meta_write1(meta_write1), .meta_write2(meta_write2),
    .meta_out1(meta_out1), .meta_out2(meta_out2),
    .fill_done(fill_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       w1;
    logic       w2;
    logic [7:0] en;
    logic [15:0] d;
  } wr_t;

  typedef struct packed {
    logic [7:0] m1;
    logic [7:0] m2;
  } meta_t;

  logic [15:0] expReq[$];
  wr_t         expWr[$];
  meta_t       expMeta[$];

  // Memory responder state
  typedef struct {
    logic [15:0] addr;
    int          ready;
  } pend_t;
  pend_t       pend[$];
  bit          gatePat[$];
  int          gatePct  = 100;
  int          memLat   = 3;
  bit          dataIdx  = 1'b1;
  logic [15:0] salt     = 16'h0;
  bit          spurious = 1'b0;
  int          cycleNo  = 0;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (dataIdx) return 16'h1000 + 16'(a[3:1]);
    return a ^ salt ^ 16'h3C5A;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Replacement rule: invalid way first; both valid -> way 2 only if it alone is LRU.
  function automatic bit pickWay2(input logic [7:0] m1, input logic [7:0] m2);
    if (!m1[7]) return 1'b0;
    if (!m2[7]) return 1'b1;
    return m2[6] && !m1[6];
  endfunction

  // Reference model: everything one miss should produce.
  task automatic expectFill(input logic [15:0] a, input logic [7:0] m1, input logic [7:0] m2);
    bit          w2;
    logic [15:0] base;
    logic [15:0] wa;
    logic [7:0]  nm;
    wr_t         w;
    meta_t       m;
    w2   = pickWay2(m1, m2);
    base = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      wa = base + 16'(2 * i);
      expReq.push_back(wa);
      w.w1 = !w2;
      w.w2 = w2;
      w.en = 8'(1 << i);
      w.d  = memWord(wa);
      expWr.push_back(w);
    end
    nm = {2'b10, a[15:10]};
    if (w2) begin
      m.m1 = m1 | 8'h40;
      m.m2 = nm;
    end else begin
      m.m1 = nm;
      m.m2 = m2 | 8'h40;
    end
    expMeta.push_back(m);
  endtask

  // Memory: captures requests, returns them in order after memLat cycles, optionally gated.
  initial begin
    bit    g;
    pend_t p;
    mem_data_valid = 1'b0;
    mem_data_in    = 16'h0;
    forever begin
      @(posedge clk);
      cycleNo++;
      #1;
      mem_data_valid = 1'b0;
      mem_data_in    = 16'h0;
      if (pend.size() > 0 && pend[0].ready <= cycleNo) begin
        if (gatePat.size() > 0) g = gatePat.pop_front();
        else g = ($urandom_range(99) < gatePct);
        if (g) begin
          p = pend.pop_front();
          mem_data_valid = 1'b1;
          mem_data_in    = memWord(p.addr);
        end
      end else if (spurious) begin
        mem_data_valid = 1'b1;
        mem_data_in    = 16'hDEAD;
      end
      @(negedge clk);
      if (mem_read_en) begin
        p.addr  = mem_addr;
        p.ready = cycleNo + memLat;
        pend.push_back(p);
      end
    end
  end

  // Monitor: pop and compare on every DUT strobe.
  initial begin
    logic [15:0] eReq;
    wr_t         eWr;
    meta_t       eMeta;
    forever begin
      @(negedge clk);
      if (mem_read_en) begin
        if (expReq.size() == 0) check("unexpected_req", 64'(mem_addr), 64'hFFFF_FFFF);
        else begin
          eReq = expReq.pop_front();
          check("req_addr", 64'(mem_addr), 64'(eReq));
        end
      end
      if (data_write1 || data_write2) begin
        if (expWr.size() == 0) check("unexpected_data_write", 64'({data_write1, data_write2, word_en, data_out}), 64'h0);
        else begin
          eWr = expWr.pop_front();
          check("data_write", 64'({data_write1, data_write2, word_en, data_out}), 64'(eWr));
        end
      end
      if (meta_write1 || meta_write2 || fill_done) begin
        if (expMeta.size() == 0) check("unexpected_meta_write", 64'({meta_write1, meta_write2, fill_done, meta_out1, meta_out2}), 64'h0);
        else begin
          eMeta = expMeta.pop_front();
          check("meta_update", 64'({meta_write1, meta_write2, fill_done, meta_out1, meta_out2}),
                64'({3'b111, eMeta.m1, eMeta.m2}));
        end
      end
    end
  end

  function automatic logic [63:0] allOutputs();
    return 64'({fsm_busy, mem_read_en, mem_addr, data_write1, data_write2, word_en, data_out,
                meta_write1, meta_write2, meta_out1, meta_out2, fill_done});
  endfunction

  // One complete miss; expBusy > 0 also checks the length of the busy window.
  task automatic doMiss(input logic [15:0] a, input logic [7:0] m1, input logic [7:0] m2,
                        input bit hold, input int expBusy);
    int busyCnt = 0;
    int doneCnt = 0;
    int guard   = 0;
    bit done    = 1'b0;
    bit sawDone = 1'b0;
    expectFill(a, m1, m2);
    @(posedge clk); #1;
    miss_detected = 1'b1;
    miss_address  = a;
    meta1         = m1;
    meta2         = m2;
    @(negedge clk);
    check("busy_at_accept", 64'(fsm_busy), 64'h0);
    while (!done && guard < 400) begin
      @(posedge clk); #1;
      if (!hold || sawDone) miss_detected = 1'b0;
      miss_address = 16'($urandom);
      meta1        = 8'($urandom);
      meta2        = 8'($urandom);
      @(negedge clk);
      if (fsm_busy) busyCnt++;
      else if (busyCnt > 0) done = 1'b1;
      if (fill_done) begin
        doneCnt++;
        sawDone = 1'b1;
      end
      guard++;
    end
    miss_detected = 1'b0;
    if (!done) check("fill_timeout", 64'(busyCnt), 64'hFFFF_FFFF);
    if (expBusy > 0) check("busy_cycles", 64'(busyCnt), 64'(expBusy));
    check("fill_done_pulses", 64'(doneCnt), 64'h1);
    check("queues_drained", 64'(expReq.size() + expWr.size() + expMeta.size()), 64'h0);
  endtask

  task automatic idleSpurious();
    @(negedge clk);
    spurious = 1'b1;
    @(negedge clk);
    check("idle_spurious_write", 64'({data_write1, data_write2, meta_write1, meta_write2, fill_done}), 64'h0);
    spurious = 1'b0;
  endtask

  initial begin
    int          strobes;
    logic [11:0] patBits;
    logic [7:0]  rm1;
    logic [7:0]  rm2;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address  = 16'h0;
    meta1 = 8'h0;
    meta2 = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", allOutputs(), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during the third FILL cycle aborts the fill.
    dataIdx = 1'b1; memLat = 3; gatePct = 100;
    expectFill(16'hABC6, 8'h00, 8'h00);
    @(posedge clk); #1;
    miss_detected = 1'b1; miss_address = 16'hABC6;
    @(posedge clk); #1;
    miss_detected = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expReq.delete(); expWr.delete(); expMeta.delete();
    @(negedge clk);
    check("after_reset_outputs", allOutputs(), 64'h0);
    strobes = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_write1 || data_write2 || meta_write1 || meta_write2 || fill_done || fsm_busy) strobes++;
    end
    check("aborted_fill_strobes", 64'(strobes), 64'h0);
    pend.delete();

    // Directed fills, returns 3 cycles after each request
    doMiss(16'h1234, 8'h00, 8'h00, 1'b0, 12);
    doMiss(16'hFC10, 8'hC5, 8'h00, 1'b0, 12);
    doMiss(16'h0800, 8'h83, 8'hC9, 1'b0, 12);
    doMiss(16'h5A3E, 8'h8A, 8'h95, 1'b1, 12);

    // Irregular returns and a stray valid while idle
    idleSpurious();
    memLat  = 1;
    patBits = 12'b1001_1011_1011;
    for (int i = 11; i >= 0; i--) gatePat.push_back(patBits[i]);
    doMiss(16'h2468, 8'hC0, 8'h81, 1'b0, 0);
    check("gate_pattern_used", 64'(gatePat.size()), 64'h0);
    idleSpurious();

    // Randomized fills
    dataIdx = 1'b0;
    for (int n = 0; n < 24; n++) begin
      salt    = 16'($urandom);
      memLat  = $urandom_range(1, 6);
      gatePct = $urandom_range(30, 100);
      rm1     = 8'($urandom);
      rm2     = 8'($urandom);
      if ($urandom_range(3) == 0) idleSpurious();
      doMiss(16'($urandom), rm1, rm2, 1'($urandom_range(1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
